// File: rtl/ru_wb.sv
// Register unit with writeback-source mux, x0 hardwired to zero and a committed-write counter.
// Optional build macro: RU_BYPASS_EN (same-cycle write-through on the read ports).
module ru_wb #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [$clog2(NREG)-1:0]  rs1,
  input  logic [$clog2(NREG)-1:0]  rs2,
  input  logic [$clog2(NREG)-1:0]  rd,
  input  logic                     ruWr,
  input  logic [1:0]               ruDataWrSrc,
  input  logic [XLEN-1:0]          aluRes,
  input  logic [XLEN-1:0]          dmDataRd,
  input  logic [XLEN-1:0]          pcInc,
  output logic [XLEN-1:0]          ru_rs1,
  output logic [XLEN-1:0]          ru_rs2,
  output logic [XLEN-1:0]          ruDataWr,
  output logic [31:0]              wbCount
);

  localparam int AW = $clog2(NREG);
  localparam logic [1:0] SRC_ALU = 2'b00;
  localparam logic [1:0] SRC_DM  = 2'b01;
  localparam logic [1:0] SRC_PC  = 2'b10;

  logic [XLEN-1:0] regs_q [NREG];
  logic [31:0]     wb_count_q;
  logic [31:0]     wb_count_d;
  logic            commit;

  // Reserved select drives zero so nothing meaningful can leak into the array.
  always_comb begin
    ruDataWr = '0;
    case (ruDataWrSrc)
      SRC_ALU: ruDataWr = aluRes;
      SRC_DM:  ruDataWr = dmDataRd;
      SRC_PC:  ruDataWr = pcInc;
      default: ruDataWr = '0;
    endcase
  end

  assign commit     = !rst && ruWr && (rd != '0) && (ruDataWrSrc != 2'b11);
  assign wb_count_d = commit ? wb_count_q + 32'd1 : wb_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      if (commit) begin
        regs_q[rd] <= ruDataWr;
      end
      wb_count_q <= wb_count_d;
    end
  end

  // x0 entry is never written, but the explicit zero keeps reads of it independent of the array.
  always_comb begin
    ru_rs1 = (rs1 == '0) ? '0 : regs_q[rs1];
    ru_rs2 = (rs2 == '0) ? '0 : regs_q[rs2];
`ifdef RU_BYPASS_EN
    if (commit && (rs1 == rd)) ru_rs1 = ruDataWr;
    if (commit && (rs2 == rd)) ru_rs2 = ruDataWr;
`else
    // Without write-through the array value is seen until after the committing edge.
`endif
  end

  assign wbCount = wb_count_q;

  logic unused_aw;
  assign unused_aw = (AW == 0);

endmodule

// File: tb/tb_ru_wb.sv
// Self-checking bench for ru_wb: directed scenarios plus random traffic against a simple array model.
module tb_ru_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd;
  logic        ruWr;
  logic [1:0]  ruDataWrSrc;
  logic [31:0] aluRes, dmDataRd, pcInc;
  logic [31:0] ru_rs1, ru_rs2, ruDataWr, wbCount;

  int checks = 0;
  int fails  = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_count;

`ifdef RU_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  ru_wb #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .rd(rd), .ruWr(ruWr),
    .ruDataWrSrc(ruDataWrSrc), .aluRes(aluRes), .dmDataRd(dmDataRd), .pcInc(pcInc),
    .ru_rs1(ru_rs1), .ru_rs2(ru_rs2), .ruDataWr(ruDataWr), .wbCount(wbCount)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic w, input logic [4:0] d, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] m, input logic [31:0] p,
                       input logic [4:0] a1, input logic [4:0] a2);
    rst = r; ruWr = w; rd = d; ruDataWrSrc = s;
    aluRes = a; dmDataRd = m; pcInc = p; rs1 = a1; rs2 = a2;
    #2;
  endtask

  // Model: apply the rules for one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] v;
    v = (ruDataWrSrc == 2'd0) ? aluRes : (ruDataWrSrc == 2'd1) ? dmDataRd :
        (ruDataWrSrc == 2'd2) ? pcInc : 32'd0;
    if (rst) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_count = 32'd0;
    end else if (ruWr && rd != 5'd0 && ruDataWrSrc != 2'd3) begin
      m_regs[rd] = v;
      m_count    = m_count + 32'd1;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 1, 5, 0, 32'hDEADBEEF, 0, 0, 5, 0); tick();
    checks++; if (ru_rs1 !== 32'hDEADBEEF) begin fails++; $display("FAIL reset_pre_x5 got=%h exp=%h", ru_rs1, 32'hDEADBEEF); end
    drive(1, 0, 0, 0, 0, 0, 0, 5, 5); tick();
    checks++; if (ru_rs1 !== 32'd0) begin fails++; $display("FAIL reset_x5 got=%h exp=0", ru_rs1); end
    checks++; if (wbCount !== 32'd0) begin fails++; $display("FAIL reset_count got=%h exp=0", wbCount); end
    checks++; if (ru_rs2 !== 32'd0) begin fails++; $display("FAIL reset_rs2 got=%h exp=0", ru_rs2); end
    $display("test_reset done");
  endtask

  task automatic test_sources();
    for (int s = 0; s < 3; s++) begin
      drive(0, 1, 5'(s + 1), 2'(s), 32'h11, 32'h22, 32'h33, 0, 0);
      checks++; if (ruDataWr !== 32'h11 * (s + 1)) begin fails++; $display("FAIL src_mux s=%0d got=%h exp=%h", s, ruDataWr, 32'h11 * (s + 1)); end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1, 2);
    checks++; if (ru_rs1 !== 32'h11) begin fails++; $display("FAIL src_x1 got=%h exp=11", ru_rs1); end
    checks++; if (ru_rs2 !== 32'h22) begin fails++; $display("FAIL src_x2 got=%h exp=22", ru_rs2); end
    drive(0, 0, 0, 0, 0, 0, 0, 3, 3);
    checks++; if (ru_rs1 !== 32'h33) begin fails++; $display("FAIL src_x3 got=%h exp=33", ru_rs1); end
    checks++; if (wbCount !== 32'd3) begin fails++; $display("FAIL src_count got=%0d exp=3", wbCount); end
    $display("test_sources done");
  endtask

  task automatic test_discard();
    drive(0, 1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0); tick();
    checks++; if (ru_rs1 !== 32'd0) begin fails++; $display("FAIL x0_read got=%h exp=0", ru_rs1); end
    drive(0, 1, 4, 3, 32'h12345678, 32'h9ABCDEF0, 32'h0BADF00D, 4, 0);
    checks++; if (ruDataWr !== 32'd0) begin fails++; $display("FAIL rsvd_mux got=%h exp=0", ruDataWr); end
    tick();
    checks++; if (ru_rs1 !== 32'd0) begin fails++; $display("FAIL rsvd_x4 got=%h exp=0", ru_rs1); end
    checks++; if (wbCount !== 32'd3) begin fails++; $display("FAIL discard_count got=%0d exp=3", wbCount); end
    $display("test_discard done");
  endtask

  task automatic test_bypass();
    logic [31:0] exp_in;
    drive(0, 1, 7, 0, 32'hA, 0, 0, 0, 0); tick();
    drive(0, 1, 7, 0, 32'hB, 0, 0, 7, 7);
    exp_in = BYPASS ? 32'hB : 32'hA;
    checks++; if (ru_rs1 !== exp_in) begin fails++; $display("FAIL same_cycle_rs1 got=%h exp=%h", ru_rs1, exp_in); end
    checks++; if (ru_rs2 !== exp_in) begin fails++; $display("FAIL same_cycle_rs2 got=%h exp=%h", ru_rs2, exp_in); end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 7, 7);
    checks++; if (ru_rs1 !== 32'hB || ru_rs2 !== 32'hB) begin fails++; $display("FAIL after_edge_x7 got=%h/%h exp=b", ru_rs1, ru_rs2); end
    $display("test_bypass done");
  endtask

  task automatic test_reset_priority();
    drive(1, 1, 9, 0, 32'h55, 0, 0, 9, 9); tick();
    checks++; if (ru_rs1 !== 32'd0) begin fails++; $display("FAIL rstwin_x9 got=%h exp=0", ru_rs1); end
    checks++; if (wbCount !== 32'd0) begin fails++; $display("FAIL rstwin_count got=%0d exp=0", wbCount); end
    drive(0, 1, 9, 0, 32'h55, 0, 0, 9, 9); tick();
    checks++; if (ru_rs1 !== 32'h55) begin fails++; $display("FAIL rstrel_x9 got=%h exp=55", ru_rs1); end
    checks++; if (wbCount !== 32'd1) begin fails++; $display("FAIL rstrel_count got=%0d exp=1", wbCount); end
    $display("test_reset_priority done");
  endtask

  task automatic test_wrap();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    dut.wb_count_q = 32'hFFFFFFFE;
    m_count = 32'hFFFFFFFE;
    drive(0, 1, 10, 0, 32'h1, 0, 0, 0, 0); tick();
    checks++; if (wbCount !== 32'hFFFFFFFF) begin fails++; $display("FAIL wrap_first got=%h exp=ffffffff", wbCount); end
    drive(0, 1, 11, 0, 32'h2, 0, 0, 0, 0); tick();
    checks++; if (wbCount !== 32'h0) begin fails++; $display("FAIL wrap_second got=%h exp=0", wbCount); end
    $display("test_wrap done");
  endtask

  task automatic test_random();
    logic [31:0] exp_wd, exp1, exp2;
    logic        com;
    for (int n = 0; n < 80; n++) begin
      logic [4:0] d, a1, a2;
      d  = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? d : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 29) == 0), 1'($urandom_range(0, 1)), d, 2'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom, a1, a2);
      exp_wd = (ruDataWrSrc == 2'd0) ? aluRes : (ruDataWrSrc == 2'd1) ? dmDataRd :
               (ruDataWrSrc == 2'd2) ? pcInc : 32'd0;
      com  = !rst && ruWr && d != 5'd0 && ruDataWrSrc != 2'd3;
      exp1 = (a1 == 5'd0) ? 32'd0 : (BYPASS && com && a1 == d) ? exp_wd : m_regs[a1];
      exp2 = (a2 == 5'd0) ? 32'd0 : (BYPASS && com && a2 == d) ? exp_wd : m_regs[a2];
      checks++; if (ruDataWr !== exp_wd) begin fails++; $display("FAIL rnd_wd n=%0d got=%h exp=%h", n, ruDataWr, exp_wd); end
      checks++; if (ru_rs1 !== exp1) begin fails++; $display("FAIL rnd_rs1 n=%0d got=%h exp=%h", n, ru_rs1, exp1); end
      checks++; if (ru_rs2 !== exp2) begin fails++; $display("FAIL rnd_rs2 n=%0d got=%h exp=%h", n, ru_rs2, exp2); end
      $display("txn %0d rst=%0d wr=%0d rd=%0d src=%0d wd=%h rs1=%0d:%h rs2=%0d:%h", n, rst, ruWr, d,
               ruDataWrSrc, ruDataWr, a1, ru_rs1, a2, ru_rs2);
      tick();
      checks++; if (wbCount !== m_count) begin fails++; $display("FAIL rnd_count n=%0d got=%h exp=%h", n, wbCount, m_count); end
    end
    $display("test_random done");
  endtask

  initial begin
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_count = 32'd0;
    @(negedge clk);
    test_reset();
    test_sources();
    test_discard();
    test_bypass();
    test_reset_priority();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/ru_wb.md
# ru_wb

Register unit with integrated writeback-source selection for the RV32I single-cycle core. It is the write end of the operand path: it supplies `ru_rs1` and `ru_rs2` to the ALU operand muxes and commits the selected writeback value into `rd` at the clock edge. It also keeps a committed-write counter used by the benches for retirement checks.

## Interface
Parameters:
- `XLEN`, 32, data width.
- `NREG`, 32, number of architectural registers. The address width is log2(NREG), which is 5.

Ports:
- `clk`  in  1  core clock. Everything in the block is rising-edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `rs1`  in  5  read address, port 1.
- `rs2`  in  5  read address, port 2.
- `rd`  in  5  write address.
- `ruWr`  in  1  write enable from the control unit.
- `ruDataWrSrc`  in  2  writeback source select:
  - 00 selects `aluRes`.
  - 01 selects `dmDataRd`.
  - 10 selects `pcInc`.
  - 11 is reserved.
- `aluRes`  in  XLEN  ALU result.
- `dmDataRd`  in  XLEN  data-memory load data.
- `pcInc`  in  XLEN  PC+4.
- `ru_rs1`  out  XLEN  contents of register `rs1`.
- `ru_rs2`  out  XLEN  contents of register `rs2`.
- `ruDataWr`  out  XLEN  selected writeback value (combinational, for observation).
- `wbCount`  out  32  count of committed writes.

## Operation
- **Storage:** NREG x XLEN register array. x0 is hardwired to zero.
  - Reads of address 0 always return 0.
  - Writes to address 0 are discarded and are not counted.
- **Writeback mux:** `ruDataWr` is selected per `ruDataWrSrc`. For the reserved code 11, `ruDataWr` = 0 and the write is suppressed, even when `ruWr` = 1.
- **Commit condition:** `rst`=0, `ruWr`=1, `rd`≠0, and `ruDataWrSrc`≠11.
  - On commit, reg[rd] ← `ruDataWr` at the rising edge.
  - On commit, `wbCount` increments by 1, modulo 2^32. It wraps from 0xFFFFFFFF to 0.
- **Reads:** combinational from the array, with no internal state on the read path beyond the array itself.
- **Same-cycle read of the register being written:** governed by `RU_BYPASS_EN` (see Configuration).
- **Reset:** when `rst`=1 at an edge, all registers and `wbCount` clear to 0.
  - Reset has priority over a simultaneous write; that write is lost and not counted.
  - From the first edge with `rst` high, `ru_rs1`, `ru_rs2` and `wbCount` read 0.
  - `ruDataWr` stays combinational on its inputs during reset.
- **Reset mid-stream:** a write presented in the cycle `rst` deasserts (`rst` sampled 0) commits normally.
- **Two reads of the same address:** both ports return identical values.

## Timing
- Write latency: 1 cycle. The value is visible on read ports combinationally after the committing edge.
- Read latency: 0 cycles, combinational from address to data.
- `wbCount` updates on the same edge as the committing write.
- Reset values:
  - `ru_rs1` = 0, `ru_rs2` = 0, `wbCount` = 0.
  - All array entries = 0.
- No handshake. Each cycle is independent; there is at most one write per cycle.
- Single-cycle core constraint: the path `rs1` → `ru_rs1` → ALU → `aluRes` → `ruDataWr` is one combinational path. The array write must be edge-registered only; no write-side latches.

## Configuration
- Macro: `RU_BYPASS_EN`.
- **Defined:** when a commit condition holds for `rd` and `rs1` (or `rs2`) equals `rd` with `rd`≠0, the read port returns `ruDataWr` in that same cycle (write-through).
- **Undefined:** the read port returns the old array contents until after the edge.
- `wbCount` behaviour and x0 behaviour are identical in both builds.

## Test plan
1. **Reset clears state.** Write 0xDEADBEEF to x5, assert `rst` for one edge, then read `rs1`=5.
   - Required: `ru_rs1`=0 and `wbCount`=0.
2. **All three sources commit correctly.**
   - Stimulus: `aluRes`=0x11, `dmDataRd`=0x22, `pcInc`=0x33. Write x1 with src 00, x2 with src 01, x3 with src 10.
   - Required: reading back gives 0x11, 0x22, 0x33, and `wbCount`=3.
3. **x0 and reserved code are discarded.**
   - Stimulus: write `rd`=0 with `aluRes`=0xFFFFFFFF; then write `rd`=4 with src 11.
   - Required: x0 reads 0, x4 is unchanged at 0, `wbCount` is unchanged, and `ruDataWr`=0 during the src 11 cycle.
4. **Same-cycle read/write of x7.** x7 holds 0xA; write 0xB to x7 with `rs1`=`rs2`=7.
   - Required in the write cycle: `ru_rs1`=`ru_rs2`=0xB with `RU_BYPASS_EN` defined, 0xA without it.
   - Required after the edge: 0xB in both builds.
5. **Reset wins over a simultaneous write.** Assert `rst`=1 and `ruWr`=1 with `rd`=9, data 0x55.
   - Required: x9=0 and `wbCount`=0 after the edge.
   - Then deassert `rst` and repeat the write: x9=0x55 and `wbCount`=1.
6. **Counter wrap.** Force `wbCount` to 0xFFFFFFFE (via hierarchical deposit), then perform 2 valid writes.
   - Required: `wbCount` reads 0xFFFFFFFF, then 0x00000000.
